muldiv_ctrl: RTL and testbench

Sequencer that owns the HI/LO register pair and drives the shared multiplier and divider units of the multicycle CPU. It accepts one MULT/DIV/MTHI/MTLO request at a time from the main control unit. It clears and starts the selected arithmetic unit, waits for its completion flag with a timeout, and commits the result into HI/LO. Divide-by-zero is trapped before the divider is started.

---
 rtl/muldiv_ctrl_if.sv | 23 ++
 rtl/muldiv_ctrl.sv | 146 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Request/response channel between the main control unit and the HI/LO sequencer.
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        op_done;
  logic        div_zero;
  logic        timeout_err;

  // Requester side (main control unit)
  modport master (
    output op_valid, op_code, rs_val, rt_val,
    input  op_ready, op_done, div_zero, timeout_err
  );

  // Sequencer side
  modport slave (
    input  op_valid, op_code, rs_val, rt_val,
    output op_ready, op_done, div_zero, timeout_err
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for the shared multiplier/divider units.
// One request at a time: clear unit, start it, wait for done (bounded), commit.
module muldiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_ctrl_if.slave req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_clr,
  output logic        div_clr,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLR   = 2'd1;
  localparam logic [1:0] START = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  logic [1:0]       state;
  logic             sel;   // 0 = multiplier, 1 = divider
  logic [CNT_W-1:0] cnt;
  logic             op_done_q, div_zero_q, timeout_err_q;

  logic        sel_done;
  logic [31:0] sel_hi, sel_lo;

  // Only the selected unit's completion flag and result are ever looked at.
  always_comb begin
    sel_done = sel ? div_done : mult_done;
    sel_hi   = sel ? div_hi   : mult_hi;
    sel_lo   = sel ? div_lo   : mult_lo;
  end

  assign req.op_ready    = (state == IDLE);
  assign req.op_done     = op_done_q;
  assign req.div_zero    = div_zero_q;
  assign req.timeout_err = timeout_err_q;

  // Sequencer: pulses/strobes are registered and default low every cycle,
  // so each is set on the edge entering the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sel           <= 1'b0;
      cnt           <= '0;
      hi            <= '0;
      lo            <= '0;
      unit_a        <= '0;
      unit_b        <= '0;
      mult_clr      <= 1'b0;
      div_clr       <= 1'b0;
      mult_start    <= 1'b0;
      div_start     <= 1'b0;
      op_done_q     <= 1'b0;
      div_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      mult_clr      <= 1'b0;
      div_clr       <= 1'b0;
      mult_start    <= 1'b0;
      div_start     <= 1'b0;
      op_done_q     <= 1'b0;
      div_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req.op_valid) begin
            case (req.op_code)
              OP_MULT: begin
                unit_a   <= req.rs_val;
                unit_b   <= req.rt_val;
                sel      <= 1'b0;
                mult_clr <= 1'b1;
                state    <= CLR;
              end
              OP_DIV: begin
                // Zero divisor is trapped here; the divider is never touched.
                if (req.rt_val == 32'd0) begin
                  div_zero_q <= 1'b1;
                end else begin
                  unit_a  <= req.rs_val;
                  unit_b  <= req.rt_val;
                  sel     <= 1'b1;
                  div_clr <= 1'b1;
                  state   <= CLR;
                end
              end
              OP_MTHI: begin
                hi        <= req.rs_val;
                op_done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo        <= req.rs_val;
                op_done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CLR: begin
          // clr was high this cycle, dropping any stale done; start next.
          mult_start <= ~sel;
          div_start  <= sel;
          state      <= START;
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done takes priority over the timeout limit in the same cycle.
          if (sel_done) begin
            hi        <= sel_hi;
            lo        <= sel_lo;
            op_done_q <= 1'b1;
            state     <= IDLE;
          end else if (cnt == CNT_LIM) begin
            timeout_err_q <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: stub mult/div units, directed requests, and a
// scoreboard monitor that checks every response pulse (kind, HI/LO, cycle).
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if rq();

  logic [31:0] hi, lo, unit_a, unit_b;
  logic        mult_clr, div_clr, mult_start, div_start;
  logic        m_done = 1'b0, d_done = 1'b0;
  logic [31:0] m_hi_o = 32'hBAD0BAD0, m_lo_o = 32'hBAD1BAD1;
  logic [31:0] d_hi_o = 32'hBAD2BAD2, d_lo_o = 32'hBAD3BAD3;

  muldiv_ctrl #(.TIMEOUT(40)) dut (
    .clk(clk), .reset(reset), .req(rq),
    .hi(hi), .lo(lo), .unit_a(unit_a), .unit_b(unit_b),
    .mult_clr(mult_clr), .div_clr(div_clr),
    .mult_start(mult_start), .div_start(div_start),
    .mult_done(m_done), .div_done(d_done),
    .mult_hi(m_hi_o), .mult_lo(m_lo_o), .div_hi(d_hi_o), .div_lo(d_lo_o)
  );

  // Stub units: clr drops sticky done; start loads a latency (0 = never).
  int mlat = 0, dlat = 0, m_cnt = 0, d_cnt = 0;
  logic m_stick = 1'b0;
  logic [31:0] m_rhi, m_rlo, d_rhi, d_rlo;
  always @(posedge clk) begin
    if (m_stick) m_done <= 1'b1;
    else if (mult_clr) m_done <= 1'b0;
    if (mult_start) m_cnt <= mlat;
    else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin m_done <= 1'b1; m_hi_o <= m_rhi; m_lo_o <= m_rlo; end
    end
    if (div_clr) d_done <= 1'b0;
    if (div_start) d_cnt <= dlat;
    else if (d_cnt > 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) begin d_done <= 1'b1; d_hi_o <= d_rhi; d_lo_o <= d_rlo; end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int n_mclr = 0, n_dclr = 0, n_mst = 0, n_dst = 0;
  logic [31:0] mh = 0, ml = 0;  // reference HI/LO

  typedef struct { logic [1:0] kind; logic [31:0] hi; logic [31:0] lo; int at; } exp_t;
  exp_t sb[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse pops one expectation.
  always @(negedge clk) begin
    int np;
    exp_t e;
    np = int'(rq.op_done) + int'(rq.div_zero) + int'(rq.timeout_err);
    if (mult_clr) n_mclr++;
    if (div_clr) n_dclr++;
    if (mult_start) n_mst++;
    if (div_start) n_dst++;
    if (np > 1) chk("one_pulse", np, 1);
    if (np != 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {rq.op_done, rq.div_zero, rq.timeout_err}, 0);
      end else begin
        e = sb.pop_front();
        chk("kind", rq.op_done ? 0 : (rq.div_zero ? 1 : 2), e.kind);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("cycle", cyc, e.at);
        chk("ready_at_resp", rq.op_ready, 1);
      end
    end
  end

  // Issue one request once ready; expectation (if any) due lat cycles later.
  task automatic issue(logic [2:0] code, logic [31:0] a, logic [31:0] b,
                       bit en, logic [1:0] k, logic [31:0] eh, logic [31:0] el, int lat);
    int g = 0;
    while (!rq.op_ready && g < 200) begin @(negedge clk); g++; end
    if (!rq.op_ready) chk("ready_timeout", 0, 1);
    rq.op_valid = 1'b1; rq.op_code = code; rq.rs_val = a; rq.rt_val = b;
    if (en) sb.push_back('{k, eh, el, cyc + lat});
    @(negedge clk);
    rq.op_valid = 1'b0;
  endtask

  task automatic drain(int max);
    int g = 0;
    while (sb.size() != 0 && g < max) begin @(negedge clk); g++; end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0;
    bit held;
    rq.op_valid = 1'b0; rq.op_code = 0; rq.rs_val = 0; rq.rt_val = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", rq.op_ready, 1);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_units", {unit_a, unit_b}, 0);
    chk("rst_strobes", {mult_clr, div_clr, mult_start, div_start}, 0);

    // MTHI then MTLO back-to-back
    mh = 32'hDEADBEEF;
    issue(3'b010, 32'hDEADBEEF, 0, 1, 0, mh, ml, 1);
    ml = 32'h12345678;
    issue(3'b011, 32'h12345678, 0, 1, 0, mh, ml, 1);
    drain(10);

    // DIV by zero: trap, no unit activity, still ready
    c0 = n_dclr + n_dst + n_mclr + n_mst;
    issue(3'b001, 5, 0, 1, 1, mh, ml, 1);
    chk("dz_ready", rq.op_ready, 1);
    drain(10);
    idle(2);
    chk("dz_no_strobes", n_dclr + n_dst + n_mclr + n_mst, c0);

    // Ignored opcode
    issue(3'b101, 32'h11111111, 32'h2, 0, 0, 0, 0, 0);
    idle(3);
    chk("ign_ready", rq.op_ready, 1);
    chk("ign_hilo", {hi, lo}, {mh, ml});

    // DIV 7 / 0xFFFFFFFE, result after 32 cycles
    dlat = 32; d_rhi = 32'h1; d_rlo = 32'hFFFFFFFD;
    mh = 32'h1; ml = 32'hFFFFFFFD;
    issue(3'b001, 7, 32'hFFFFFFFE, 1, 0, mh, ml, 36);
    chk("div_clr_c1", {div_clr, mult_clr, div_start}, 3'b100);
    @(negedge clk);
    chk("div_start_c2", {div_start, mult_start, div_clr}, 3'b100);
    held = 1;
    for (int i = 0; i < 60 && !rq.op_ready; i++) begin
      if (unit_a !== 32'd7 || unit_b !== 32'hFFFFFFFE) held = 0;
      @(negedge clk);
    end
    chk("div_operands_held", held, 1);
    drain(10);

    // MULT with stale done; op_valid while busy is ignored
    m_stick = 1'b1; @(negedge clk); m_stick = 1'b0;
    mlat = 5; m_rhi = 32'h1; m_rlo = 32'h2;
    mh = 32'h1; ml = 32'h2;
    issue(3'b000, 32'h3, 32'h4, 1, 0, mh, ml, 9);
    chk("mult_clr_c1", {mult_clr, div_clr}, 2'b10);
    @(negedge clk);
    chk("mult_start_c2", {mult_start, div_start}, 2'b10);
    @(negedge clk);
    rq.op_valid = 1'b1; rq.op_code = 3'b010; rq.rs_val = 32'h55555555;
    held = 1;
    for (int i = 0; i < 3; i++) begin
      if (unit_b !== 32'h4) held = 0;
      @(negedge clk);
    end
    rq.op_valid = 1'b0;
    chk("mult_unit_b_held", held, 1);
    drain(20);
    idle(2);
    chk("busy_req_ignored", hi, 32'h1);

    // Short MULT
    mlat = 1; m_rhi = 32'hAAAA5555; m_rlo = 32'h0F0F0F0F;
    mh = 32'hAAAA5555; ml = 32'h0F0F0F0F;
    issue(3'b000, 32'h9, 32'hA, 1, 0, mh, ml, 5);
    drain(20);

    // done on the timeout-limit cycle still commits
    dlat = 39; d_rhi = 32'h0000CAFE; d_rlo = 32'h0000F00D;
    mh = 32'h0000CAFE; ml = 32'h0000F00D;
    issue(3'b001, 32'h100, 32'h3, 1, 0, mh, ml, 43);
    drain(60);

    // Unit never finishes: timeout
    dlat = 0;
    issue(3'b001, 32'h100, 32'h3, 1, 2, mh, ml, 43);
    drain(60);
    idle(1);
    chk("to_idle", rq.op_ready, 1);

    // Reset mid-WAIT with DIV in flight; late done must not commit
    dlat = 20; d_rhi = 32'h77; d_rlo = 32'h88;
    issue(3'b001, 32'h9, 32'h3, 0, 0, 0, 0, 0);
    idle(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mh = 0; ml = 0;
    chk("mid_rst_hilo", {hi, lo}, 0);
    chk("mid_rst_ready", rq.op_ready, 1);
    chk("mid_rst_units", {unit_a, unit_b}, 0);
    chk("mid_rst_done", rq.op_done, 0);
    idle(30);
    chk("late_done_seen", d_done, 1);
    chk("late_done_ignored", {hi, lo}, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
